// File: rtl/writeback_stage.sv
// Purpose: final pipeline stage; selects, lane-extracts and registers the register-file write.
// Latency: 1 cycle from input bundle to rf_wr_* outputs.
// Backpressure: none; accepts a new bundle every cycle and never stalls.
module writeback_stage #(
    parameter int XLEN  = 64,
    parameter int RF_AW = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             valid_i,
    input  logic             rf_wr_en_i,
    input  logic [RF_AW-1:0] rd_addr_i,
    input  logic [XLEN-1:0]  alu_res_i,
    input  logic [XLEN-1:0]  data_mem_rd_i,
    input  logic [XLEN-1:0]  instr_imm_i,
    input  logic [XLEN-1:0]  pc_val_i,
    input  logic [1:0]       rf_wr_data_src_i,
    input  logic [1:0]       data_byte_en_i,
    input  logic             data_zero_extnd_i,
    input  logic [2:0]       data_mem_row_idx_i,
    output logic             rf_wr_en_o,
    output logic [RF_AW-1:0] rf_wr_addr_o,
    output logic [XLEN-1:0]  rf_wr_data_o
);

    localparam logic [1:0] SRC_ALU = 2'b00;
    localparam logic [1:0] SRC_MEM = 2'b01;
    localparam logic [1:0] SRC_IMM = 2'b10;
    localparam logic [1:0] SRC_PC  = 2'b11;

    localparam logic [1:0] SZ_BYTE  = 2'b00;
    localparam logic [1:0] SZ_HALF  = 2'b01;
    localparam logic [1:0] SZ_WORD  = 2'b10;
    localparam logic [1:0] SZ_DWORD = 2'b11;

    logic [XLEN-1:0] lane_src;
    logic [5:0]      shift_amt;
    logic [XLEN-1:0] shifted;
    logic            sign_fill;
    logic [XLEN-1:0] ext_data;
    logic [XLEN-1:0] wr_data_nxt;

    // Lane source, byte shift and sign/zero extension for ALU and memory results
    always_comb begin
        lane_src  = alu_res_i;
        shift_amt = 6'd0;
        shifted   = '0;
        sign_fill = 1'b0;
        ext_data  = '0;

        // Only memory reads are positioned within the row; ALU results are already aligned.
        // A double-word access always takes the whole row unshifted.
        if (rf_wr_data_src_i == SRC_MEM) begin
            lane_src = data_mem_rd_i;
            if (data_byte_en_i != SZ_DWORD) begin
                shift_amt = {data_mem_row_idx_i, 3'b000};
            end
        end

        // Logical shift: bytes past the top of the row come in as zero.
        shifted = lane_src >> shift_amt;

        // data_zero_extnd_i = 1 requests sign extension despite its name.
        case (data_byte_en_i)
            SZ_BYTE: begin
                sign_fill = data_zero_extnd_i & shifted[7];
                ext_data  = {{(XLEN-8){sign_fill}}, shifted[7:0]};
            end
            SZ_HALF: begin
                sign_fill = data_zero_extnd_i & shifted[15];
                ext_data  = {{(XLEN-16){sign_fill}}, shifted[15:0]};
            end
            SZ_WORD: begin
                sign_fill = data_zero_extnd_i & shifted[31];
                ext_data  = {{(XLEN-32){sign_fill}}, shifted[31:0]};
            end
            SZ_DWORD: begin
                sign_fill = 1'b0;
                ext_data  = shifted;
            end
        endcase
    end

    // Final write-data mux; a full case so unselected sources cannot leak through
    always_comb begin
        wr_data_nxt = '0;
        case (rf_wr_data_src_i)
            SRC_ALU: wr_data_nxt = ext_data;
            SRC_MEM: wr_data_nxt = ext_data;
            SRC_IMM: wr_data_nxt = instr_imm_i;
            SRC_PC:  wr_data_nxt = pc_val_i;
        endcase
    end

    // Output register; address and data load every cycle, the strobe guards x0
    always_ff @(posedge clk) begin
        if (reset) begin
            rf_wr_en_o   <= 1'b0;
            rf_wr_addr_o <= '0;
            rf_wr_data_o <= '0;
        end else begin
            rf_wr_en_o   <= valid_i & rf_wr_en_i & (rd_addr_i != '0);
            rf_wr_addr_o <= rd_addr_i;
            rf_wr_data_o <= wr_data_nxt;
        end
    end

endmodule

// File: tb/tb_writeback_stage.sv
module tb_writeback_stage;

    logic        clk;
    logic        reset;
    logic        valid_i;
    logic        rf_wr_en_i;
    logic [4:0]  rd_addr_i;
    logic [63:0] alu_res_i;
    logic [63:0] data_mem_rd_i;
    logic [63:0] instr_imm_i;
    logic [63:0] pc_val_i;
    logic [1:0]  rf_wr_data_src_i;
    logic [1:0]  data_byte_en_i;
    logic        data_zero_extnd_i;
    logic [2:0]  data_mem_row_idx_i;
    logic        rf_wr_en_o;
    logic [4:0]  rf_wr_addr_o;
    logic [63:0] rf_wr_data_o;

    writeback_stage #(.XLEN(64), .RF_AW(5)) dut (
        .clk                (clk),
        .reset              (reset),
        .valid_i            (valid_i),
        .rf_wr_en_i         (rf_wr_en_i),
        .rd_addr_i          (rd_addr_i),
        .alu_res_i          (alu_res_i),
        .data_mem_rd_i      (data_mem_rd_i),
        .instr_imm_i        (instr_imm_i),
        .pc_val_i           (pc_val_i),
        .rf_wr_data_src_i   (rf_wr_data_src_i),
        .data_byte_en_i     (data_byte_en_i),
        .data_zero_extnd_i  (data_zero_extnd_i),
        .data_mem_row_idx_i (data_mem_row_idx_i),
        .rf_wr_en_o         (rf_wr_en_o),
        .rf_wr_addr_o       (rf_wr_addr_o),
        .rf_wr_data_o       (rf_wr_data_o)
    );

    typedef struct {
        int          id;
        logic        en;
        logic [4:0]  addr;
        logic [63:0] data;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   vec_id = 0;

    localparam logic [1:0] ALU = 2'b00, MEM = 2'b01, IMM = 2'b10, PC = 2'b11;
    localparam logic [1:0] BY = 2'b00, HW = 2'b01, WD = 2'b10, DW = 2'b11;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one bundle on the falling edge and queue the hand-computed result
    task automatic issue(input logic rst, input logic v, input logic we, input logic [4:0] rd,
                         input logic [1:0] src, input logic [1:0] be, input logic ext,
                         input logic [2:0] idx, input logic [63:0] alu, input logic [63:0] mem,
                         input logic [63:0] imm, input logic [63:0] pc,
                         input logic exp_en, input logic [4:0] exp_addr, input logic [63:0] exp_data);
        exp_t e;
        @(negedge clk);
        reset              = rst;
        valid_i            = v;
        rf_wr_en_i         = we;
        rd_addr_i          = rd;
        rf_wr_data_src_i   = src;
        data_byte_en_i     = be;
        data_zero_extnd_i  = ext;
        data_mem_row_idx_i = idx;
        alu_res_i          = alu;
        data_mem_rd_i      = mem;
        instr_imm_i        = imm;
        pc_val_i           = pc;
        e.id   = vec_id;
        e.en   = exp_en;
        e.addr = exp_addr;
        e.data = exp_data;
        sb.push_back(e);
        vec_id++;
    endtask

    // Monitor: one output bundle per clock, compared just after the capturing edge
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                checks++;
                if (rf_wr_en_o !== e.en) begin
                    errors++;
                    $display("FAIL vec%0d wr_en: got %b expected %b", e.id, rf_wr_en_o, e.en);
                end
                checks++;
                if (rf_wr_addr_o !== e.addr) begin
                    errors++;
                    $display("FAIL vec%0d wr_addr: got %0d expected %0d", e.id, rf_wr_addr_o, e.addr);
                end
                checks++;
                if (rf_wr_data_o !== e.data) begin
                    errors++;
                    $display("FAIL vec%0d wr_data: got %h expected %h", e.id, rf_wr_data_o, e.data);
                end
            end
        end
    end

    localparam logic [63:0] A4 = 64'hFFFF_0000_0000_0000;
    localparam logic [63:0] M4 = 64'h0000_FFFF_0000_0000;
    localparam logic [63:0] I4 = 64'h0000_0000_FFFF_0000;
    localparam logic [63:0] P4 = 64'h0000_0000_0000_FFFF;
    localparam logic [63:0] NZ = 64'hA5A5_5A5A_C3C3_3C3C;

    initial begin
        reset = 1'b1; valid_i = 1'b0; rf_wr_en_i = 1'b0; rd_addr_i = '0;
        alu_res_i = '0; data_mem_rd_i = '0; instr_imm_i = '0; pc_val_i = '0;
        rf_wr_data_src_i = '0; data_byte_en_i = '0; data_zero_extnd_i = 1'b0;
        data_mem_row_idx_i = '0;

        // Reset state, even with a live bundle on the inputs
        issue(1, 1, 1, 5'd9, ALU, DW, 0, 0, A4, M4, I4, P4, 0, 5'd0, 64'h0);
        issue(1, 1, 1, 5'd9, ALU, DW, 0, 0, A4, M4, I4, P4, 0, 5'd0, 64'h0);

        // Source select, double word, idx 0
        issue(0, 1, 1, 5'd1, ALU, DW, 0, 0, A4, M4, I4, P4, 1, 5'd1, 64'hFFFF_0000_0000_0000);
        issue(0, 1, 1, 5'd2, MEM, DW, 0, 0, A4, M4, I4, P4, 1, 5'd2, 64'h0000_FFFF_0000_0000);
        issue(0, 1, 1, 5'd3, IMM, DW, 0, 0, A4, M4, I4, P4, 1, 5'd3, 64'h0000_0000_FFFF_0000);
        issue(0, 1, 1, 5'd4, PC,  DW, 0, 0, A4, M4, I4, P4, 1, 5'd4, 64'h0000_0000_0000_FFFF);

        // ALU sign extension and IMM passthrough ignoring size/extend
        issue(0, 1, 1, 5'd5, ALU, BY, 1, 0, 64'h9C, NZ, NZ, NZ, 1, 5'd5, 64'hFFFF_FFFF_FFFF_FF9C);
        issue(0, 1, 1, 5'd6, IMM, BY, 1, 0, NZ, NZ, 64'hF0, NZ, 1, 5'd6, 64'h0000_0000_0000_00F0);

        // Memory byte lanes
        issue(0, 1, 1, 5'd7, MEM, BY, 0, 0, NZ, 64'hFBD2_67A6_10FF_4483, NZ, NZ, 1, 5'd7, 64'h83);
        issue(0, 1, 1, 5'd8, MEM, BY, 1, 1, NZ, 64'h33F0_D6DE_5453_AB57, NZ, NZ, 1, 5'd8, 64'hFFFF_FFFF_FFFF_FFAB);
        issue(0, 1, 1, 5'd9, MEM, BY, 1, 7, NZ, 64'h28FE_320D_FB19_CC8A, NZ, NZ, 1, 5'd9, 64'h28);

        // Memory half/word lanes
        issue(0, 1, 1, 5'd10, MEM, HW, 1, 6, NZ, 64'h896C_8048_EF9A_98F9, NZ, NZ, 1, 5'd10, 64'hFFFF_FFFF_FFFF_896C);
        issue(0, 1, 1, 5'd11, MEM, WD, 1, 4, NZ, 64'h37F3_A8CE_10DF_57BA, NZ, NZ, 1, 5'd11, 64'h0000_0000_37F3_A8CE);

        // Misaligned word: only two bytes remain in the row, upper half reads zero
        issue(0, 1, 1, 5'd12, MEM, WD, 1, 6, NZ, 64'h8000_1234_5678_9ABC, NZ, NZ, 1, 5'd12, 64'h0000_0000_0000_8000);
        // Zero extension of a negative half-word from the ALU
        issue(0, 1, 1, 5'd13, ALU, HW, 0, 0, 64'hFFFF_FFFF_FFFF_8001, NZ, NZ, NZ, 1, 5'd13, 64'h8001);
        // ALU ignores the row index
        issue(0, 1, 1, 5'd14, ALU, BY, 0, 3, 64'h0000_0000_1234_5678, NZ, NZ, NZ, 1, 5'd14, 64'h78);
        // Memory double word ignores row index and extend flag
        issue(0, 1, 1, 5'd15, MEM, DW, 1, 5, NZ, 64'h8123_4567_89AB_CDEF, NZ, NZ, 1, 5'd15, 64'h8123_4567_89AB_CDEF);
        // Sign-extended word with top bit set
        issue(0, 1, 1, 5'd16, MEM, WD, 1, 0, NZ, 64'h1111_2222_8765_4321, NZ, NZ, 1, 5'd16, 64'hFFFF_FFFF_8765_4321);

        // Write-enable gating: x0, valid low, wr_en low; address/data still captured
        issue(0, 1, 1, 5'd0,  PC, BY, 0, 0, NZ, NZ, NZ, 64'h1000, 0, 5'd0,  64'h1000);
        issue(0, 0, 1, 5'd17, PC, BY, 0, 0, NZ, NZ, NZ, 64'h2000, 0, 5'd17, 64'h2000);
        issue(0, 1, 0, 5'd18, PC, BY, 0, 0, NZ, NZ, NZ, 64'h3000, 0, 5'd18, 64'h3000);

        // Mid-stream reset discards the bundle; the next bundle is handled normally
        issue(0, 1, 1, 5'd19, IMM, DW, 0, 0, NZ, NZ, 64'h4444, NZ, 1, 5'd19, 64'h4444);
        issue(1, 1, 1, 5'd20, IMM, DW, 0, 0, NZ, NZ, 64'h5555, NZ, 0, 5'd0,  64'h0);
        issue(0, 1, 1, 5'd21, IMM, DW, 0, 0, NZ, NZ, 64'h6666, NZ, 1, 5'd21, 64'h6666);

        // Let the monitor drain the scoreboard within a bounded number of cycles
        for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
        #2;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d bundles left unchecked, expected 0", sb.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
